// File: rtl/stfq_rank_compute.sv
// Start-Time Fair Queueing rank stage: tags each accepted packet with a start-time
// priority from a per-flow finish table and a global virtual time, then offers it to the PIFO.
module stfq_rank_compute #(
  parameter int NUM_FLOWS    = 16,
  parameter int MAX_PRIORITY = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  localparam int FLOW_WIDTH  = $clog2(NUM_FLOWS),
  localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__pkt_valid,
  input  logic [FLOW_WIDTH-1:0] i__pkt_flow,
  input  logic [LEN_WIDTH-1:0]  i__pkt_len,
  input  logic [DATA_WIDTH-1:0] i__pkt_data,
  output logic                  o__pkt_ready,
  output logic                  o__enq_valid,
  output logic [PRIO_WIDTH-1:0] o__enq_priority,
  output logic [DATA_WIDTH-1:0] o__enq_data,
  input  logic                  i__enq_ready,
  input  logic                  i__deq_valid,
  input  logic [PRIO_WIDTH-1:0] i__deq_priority,
  input  logic                  i__clear_all
);

  localparam int SUM_W = ((LEN_WIDTH > PRIO_WIDTH) ? LEN_WIDTH : PRIO_WIDTH) + 1;
  localparam logic [PRIO_WIDTH-1:0] PRIO_MAX = PRIO_WIDTH'(MAX_PRIORITY - 1);

  logic [PRIO_WIDTH-1:0] finish_q [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]  seen_q;
  logic [PRIO_WIDTH-1:0] vtime_q;

  logic                  accept;
  logic [PRIO_WIDTH-1:0] finish_rd;
  logic [PRIO_WIDTH-1:0] start;
  logic [SUM_W-1:0]      finish_sum;
  logic [PRIO_WIDTH-1:0] finish_new;

  assign o__pkt_ready = ~reset & (~o__enq_valid | i__enq_ready);
  assign accept       = i__pkt_valid & o__pkt_ready;

  // A flow that has fallen behind virtual time restarts at vtime; the sum is
  // saturated rather than wrapped so tags never go backwards.
  always_comb begin
    finish_rd  = finish_q[i__pkt_flow];
    start      = (seen_q[i__pkt_flow] && (finish_rd > vtime_q)) ? finish_rd : vtime_q;
    finish_sum = SUM_W'(start) + SUM_W'(i__pkt_len);
    finish_new = (finish_sum > SUM_W'(MAX_PRIORITY - 1)) ? PRIO_MAX
                                                        : finish_sum[PRIO_WIDTH-1:0];
  end

  // Finish contents are only meaningful behind a seen bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept && !i__clear_all) begin
      finish_q[i__pkt_flow] <= finish_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o__enq_valid    <= 1'b0;
      o__enq_priority <= '0;
      o__enq_data     <= '0;
      vtime_q         <= '0;
      seen_q          <= '0;
    end else if (i__clear_all) begin
      o__enq_valid <= 1'b0;
      vtime_q      <= '0;
      seen_q       <= '0;
    end else begin
      if (accept) begin
        o__enq_valid             <= 1'b1;
        o__enq_priority          <= start;
        o__enq_data              <= i__pkt_data;
        seen_q[i__pkt_flow]      <= 1'b1;
      end else if (o__enq_valid && i__enq_ready) begin
        o__enq_valid <= 1'b0;
      end
      // Same-cycle accepts above already used the pre-update vtime.
      if (i__deq_valid && (i__deq_priority > vtime_q)) begin
        vtime_q <= i__deq_priority;
      end
    end
  end

endmodule

// File: tb/tb_stfq_rank_compute.sv
// Table-driven bench for stfq_rank_compute: expected tags are queued on accept
// and compared when the tagged packet is presented to the PIFO side.
module tb_stfq_rank_compute;

  logic       clk;
  logic       reset;
  logic       i__pkt_valid;
  logic [3:0] i__pkt_flow;
  logic [7:0] i__pkt_len;
  logic [7:0] i__pkt_data;
  logic       o__pkt_ready;
  logic       o__enq_valid;
  logic [7:0] o__enq_priority;
  logic [7:0] o__enq_data;
  logic       i__enq_ready;
  logic       i__deq_valid;
  logic [7:0] i__deq_priority;
  logic       i__clear_all;

  stfq_rank_compute dut (
    .clk             (clk),
    .reset           (reset),
    .i__pkt_valid    (i__pkt_valid),
    .i__pkt_flow     (i__pkt_flow),
    .i__pkt_len      (i__pkt_len),
    .i__pkt_data     (i__pkt_data),
    .o__pkt_ready    (o__pkt_ready),
    .o__enq_valid    (o__enq_valid),
    .o__enq_priority (o__enq_priority),
    .o__enq_data     (o__enq_data),
    .i__enq_ready    (i__enq_ready),
    .i__deq_valid    (i__deq_valid),
    .i__deq_priority (i__deq_priority),
    .i__clear_all    (i__clear_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pkt_valid;
    logic [3:0] flow;
    logic [7:0] len;
    logic [7:0] data;
    logic       enq_ready;
    logic       deq_valid;
    logic [7:0] deq_prio;
    logic       clear;
    logic [7:0] exp_prio;
  } vec_t;

  typedef struct {
    logic [7:0] prio;
    logic [7:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic v, logic [3:0] f, logic [7:0] l, logic [7:0] d,
                              logic rdy, logic dv, logic [7:0] dp, logic clr,
                              logic [7:0] ep);
    vec_t t;
    t.pkt_valid = v;  t.flow = f;       t.len = l;       t.data = d;
    t.enq_ready = rdy; t.deq_valid = dv; t.deq_prio = dp; t.clear = clr;
    t.exp_prio  = ep;
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    i__pkt_valid    = t.pkt_valid;
    i__pkt_flow     = t.flow;
    i__pkt_len      = t.len;
    i__pkt_data     = t.data;
    i__enq_ready    = t.enq_ready;
    i__deq_valid    = t.deq_valid;
    i__deq_priority = t.deq_prio;
    i__clear_all    = t.clear;
  endtask

  // Compares the output register against the scoreboard head and the ready flag
  // against the bench's own view of whether the register can take a packet.
  task automatic checkOutput(input int idx, input logic exp_ready);
    checkVal($sformatf("v%0d enq_valid", idx), 32'(o__enq_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      checkVal($sformatf("v%0d enq_priority", idx), 32'(o__enq_priority), 32'(sb[0].prio));
      checkVal($sformatf("v%0d enq_data", idx), 32'(o__enq_data), 32'(sb[0].data));
    end
    checkVal($sformatf("v%0d pkt_ready", idx), 32'(o__pkt_ready), 32'(exp_ready));
  endtask

  initial begin
    logic exp_ready;
    exp_t e;

    reset = 1'b1;
    applyStimulus(mk(1'b1, 4'd0, 8'd0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0));
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset enq_valid", 32'(o__enq_valid), 32'd0);
    checkVal("reset enq_priority", 32'(o__enq_priority), 32'd0);
    checkVal("reset enq_data", 32'(o__enq_data), 32'd0);
    checkVal("reset pkt_ready", 32'(o__pkt_ready), 32'd0);
    reset = 1'b0;

    //              valid flow len   data   rdy  dqv  dqp    clr  exp
    vecs.push_back(mk(1, 4'd3, 8'd10,  8'h31, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd3, 8'd5,   8'h32, 1, 0, 8'd0,  0, 8'd10));
    vecs.push_back(mk(1, 4'd1, 8'd20,  8'h11, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd2, 8'd4,   8'h21, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd1, 8'd20,  8'h12, 1, 0, 8'd0,  0, 8'd20));
    vecs.push_back(mk(1, 4'd2, 8'd4,   8'h22, 1, 0, 8'd0,  0, 8'd4));
    vecs.push_back(mk(1, 4'd0, 8'd30,  8'h01, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 1, 1, 8'd50, 0, 8'd0));
    vecs.push_back(mk(1, 4'd0, 8'd5,   8'h02, 1, 0, 8'd0,  0, 8'd50));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 1, 1, 8'd40, 0, 8'd0));
    vecs.push_back(mk(1, 4'd4, 8'd1,   8'h41, 1, 0, 8'd0,  0, 8'd50));
    vecs.push_back(mk(1, 4'd6, 8'd2,   8'h61, 1, 1, 8'd70, 0, 8'd50));
    vecs.push_back(mk(1, 4'd7, 8'd0,   8'h71, 1, 0, 8'd0,  0, 8'd70));
    vecs.push_back(mk(1, 4'd7, 8'd3,   8'h72, 1, 0, 8'd0,  0, 8'd70));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd8, 8'd5,   8'h81, 0, 0, 8'd0,  0, 8'd70));
    vecs.push_back(mk(1, 4'd8, 8'd5,   8'h82, 0, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd8, 8'd5,   8'h83, 0, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd8, 8'd5,   8'h84, 0, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd8, 8'd5,   8'h85, 1, 0, 8'd0,  0, 8'd75));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd9, 8'd1,   8'h91, 0, 0, 8'd0,  0, 8'd70));
    vecs.push_back(mk(1, 4'd3, 8'd1,   8'hEE, 1, 0, 8'd0,  1, 8'd0));
    vecs.push_back(mk(1, 4'd3, 8'd10,  8'h33, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 0, 0, 8'd0,  1, 8'd0));
    vecs.push_back(mk(1, 4'd5, 8'd200, 8'h51, 1, 0, 8'd0,  0, 8'd0));
    vecs.push_back(mk(1, 4'd5, 8'd200, 8'h52, 1, 0, 8'd0,  0, 8'd200));
    vecs.push_back(mk(1, 4'd5, 8'd7,   8'h53, 1, 0, 8'd0,  0, 8'd255));
    vecs.push_back(mk(1, 4'd5, 8'd0,   8'h54, 1, 0, 8'd0,  0, 8'd255));
    vecs.push_back(mk(0, 4'd0, 8'd0,   8'h00, 1, 0, 8'd0,  0, 8'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      exp_ready = (sb.size() == 0) || vecs[i].enq_ready;
      #1;
      checkOutput(i, exp_ready);
      @(posedge clk);
      if (sb.size() != 0 && vecs[i].enq_ready) void'(sb.pop_front());
      if (vecs[i].clear) begin
        sb.delete();
      end else if (vecs[i].pkt_valid && exp_ready) begin
        e.prio = vecs[i].exp_prio;
        e.data = vecs[i].data;
        sb.push_back(e);
      end
      #1;
    end
    checkVal("final enq_valid", 32'(o__enq_valid), 32'(sb.size() != 0));

    // Reset while a tagged packet is held must drop it and deassert ready at once.
    applyStimulus(mk(1, 4'd1, 8'd9, 8'hA5, 0, 0, 8'd0, 0, 8'd0));
    @(posedge clk);
    #1;
    checkVal("held enq_valid", 32'(o__enq_valid), 32'd1);
    checkVal("held enq_data", 32'(o__enq_data), 32'hA5);
    reset = 1'b1;
    #1;
    checkVal("mid reset pkt_ready", 32'(o__pkt_ready), 32'd0);
    @(posedge clk);
    #1;
    checkVal("post reset enq_valid", 32'(o__enq_valid), 32'd0);
    checkVal("post reset enq_priority", 32'(o__enq_priority), 32'd0);
    checkVal("post reset enq_data", 32'(o__enq_data), 32'd0);
    reset = 1'b0;
    sb.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stfq_rank_compute.md
# stfq_rank_compute

Upstream rank-computation stage for the PIFO scheduler. It implements Start-Time Fair Queueing (STFQ). Each accepted packet is tagged with a start-time priority, taken from a per-flow last-finish table and a global virtual time. The tagged packet is then enqueued into the PIFO. Virtual time advances from priorities reported by the PIFO dequeue side, so flows share the link fairly in proportion to packet length.

## Interface
Parameters:
- NUM_FLOWS, 16, number of tracked flows; FLOW_WIDTH = $clog2(NUM_FLOWS)
- MAX_PRIORITY, 256, priority range; PRIO_WIDTH = $clog2(MAX_PRIORITY); must match the downstream PIFO
- DATA_WIDTH, 8, opaque payload width, passed through unchanged
- LEN_WIDTH, 8, packet length field width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i__pkt_valid  in  1  upstream packet offered
- i__pkt_flow  in  FLOW_WIDTH  flow id
- i__pkt_len  in  LEN_WIDTH  packet length (0 legal)
- i__pkt_data  in  DATA_WIDTH  payload
- o__pkt_ready  out  1  stage can accept this cycle
- o__enq_valid  out  1  tagged packet available to PIFO
- o__enq_priority  out  PRIO_WIDTH  start-time tag
- o__enq_data  out  DATA_WIDTH  payload
- i__enq_ready  in  1  PIFO ready (PIFO's data_in_ready)
- i__deq_valid  in  1  PIFO dequeued a packet this cycle
- i__deq_priority  in  PRIO_WIDTH  priority of that dequeued packet
- i__clear_all  in  1  clear all scheduling state

## Operation
- State consists of:
  - per-flow table: finish[NUM_FLOWS] (PRIO_WIDTH bits each) plus a seen[NUM_FLOWS] valid bit per flow
  - vtime register (PRIO_WIDTH bits)
  - one output register holding valid/priority/data
- Accept condition: accept = i__pkt_valid & o__pkt_ready, where o__pkt_ready = ~reset & (~o__enq_valid | i__enq_ready).
- Tag computation (combinational on the accept cycle, using registered state):
  - start = (seen[f] && finish[f] > vtime) ? finish[f] : vtime
  - finish_new = start + i__pkt_len, computed at PRIO_WIDTH+1 bits, then saturated to MAX_PRIORITY-1
- On accept:
  - output register <= {1, start, i__pkt_data}
  - finish[f] <= finish_new
  - seen[f] <= 1
- Output register:
  - Holds its contents while o__enq_valid & ~i__enq_ready.
  - Clears valid when a transfer occurs with no new accept.
  - Transfer-and-accept in the same cycle loads the new packet (full throughput).
- Virtual time:
  - On i__deq_valid, vtime <= max(vtime, i__deq_priority). It is monotonic and never decreases.
  - A same-cycle accept uses the pre-update vtime.
- Same-flow back-to-back accepts: the table write lands at the accept edge, so the next cycle's packet sees the updated finish[f]. No forwarding path is required.
- Saturation: once finish[f] reaches MAX_PRIORITY-1, that flow's further tags are MAX_PRIORITY-1. There is no wrap-around. Software uses i__clear_all to rebase.
- i__clear_all (synchronous, lower precedence than reset):
  - Zeroes vtime and all seen bits.
  - Drops the output register (o__enq_valid <= 0).
  - Any accept in the same cycle is discarded.
  - o__pkt_ready is unaffected.

## Timing
- Latency is 1 cycle: a packet accepted at edge N appears on o__enq_* after edge N, and can transfer at edge N+1.
- Throughput is 1 packet/cycle while i__enq_ready stays high.
- Reset values:
  - o__enq_valid=0, o__enq_priority=0, o__enq_data=0
  - vtime=0, all seen=0, finish contents don't-care
  - o__pkt_ready=0 while reset is high
- Backpressure: o__enq_* remain stable while o__enq_valid & ~i__enq_ready.
- The i__deq_* inputs are sampled every cycle, independent of the enqueue handshake.

## Test plan
- After reset, flow 3, len 10, then flow 3, len 5 back-to-back with i__enq_ready=1 -> priorities 0 then 10; finish[3]=15.
- Interleave flow 1 (len 20) and flow 2 (len 4), two packets each -> priorities 0, 0, 20, 4.
- Flow 0 finish=30, then i__deq_valid with priority 50, then flow 0 packet -> priority 50. A later i__deq_priority of 40 leaves vtime at 50.
- Hold i__enq_ready=0 for 3 cycles with o__enq_valid=1 -> o__pkt_ready=0, outputs stable, no table update. On release, the next packet is accepted in the same cycle as the transfer.
- Flow 5 with len 200 then len 200 (MAX_PRIORITY=256) -> priorities 0, 200; finish saturates at 255; a third packet gets priority 255.
- Assert i__clear_all with an accept and o__enq_valid=1 -> o__enq_valid=0 next cycle; the next packet on a previously used flow gets priority 0.
